vfpmul_sequencer: RTL and testbench
===================================

Name: vfpmul_sequencer

Overview:
- Controller that sequences one vector FP multiply, C[i] = A[i] * B[i] for i = 0..VLEN-1, over the shared 32-bit register file.
- Generates register-file read addresses, issues operand pairs to the pipelined FP multiplier with a valid/ready handshake, and writes results back in order.
- Collects the per-element exception bit into a flag vector and signals completion.
- Sits between the top-level start/done interface and the multiplier/register-file datapath.

Parameters:
- VLEN, 32, vector length in elements.
- ADDR_W, 7, register-file address width; must hold C_BASE+VLEN-1.
- A_BASE, 0, base address of operand vector A.
- B_BASE, 32, base address of operand vector B.
- C_BASE, 64, base address of result vector C.
- IDX_W, 6, element counter width; must hold VLEN.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin operation; sampled in IDLE or DONE only.
- rf_rd_addr_a  out  ADDR_W  read address for A element.
- rf_rd_addr_b  out  ADDR_W  read address for B element.
- rf_rd_data_a  in  32  A operand; combinational read.
- rf_rd_data_b  in  32  B operand; combinational read.
- mul_in_valid  out  1  operand pair valid.
- mul_ready  in  1  multiplier accepts operands this cycle.
- mul_a  out  32  operand A, equal to rf_rd_data_a.
- mul_b  out  32  operand B, equal to rf_rd_data_b.
- mul_out_valid  in  1  result valid; the multiplier returns results in order.
- mul_result  in  32  product.
- mul_exc  in  1  exception for this product.
- rf_we  out  1  result write enable.
- rf_wr_addr  out  ADDR_W  write address, C_BASE + retire_idx.
- rf_wr_data  out  32  equal to mul_result.
- exc_flags  out  VLEN  per-element exception bits; registered.
- exc_any  out  1  OR of exc_flags.
- busy  out  1  high in ISSUE and DRAIN.
- done  out  1  high in DONE.
- protocol_err  out  1  sticky error flag.

Behaviour:
- Reset: state IDLE, issue_idx=0, retire_idx=0, exc_flags=0, protocol_err=0. Every output is deasserted or zero, including rf_we and mul_in_valid in the cycle after the reset edge. Reset applied mid-operation aborts immediately; results still in flight are dropped and never written.
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE --start--> ISSUE. On this edge: issue_idx=0, retire_idx=0, exc_flags=0.
- ISSUE behaviour:
  - mul_in_valid=1; rf_rd_addr_a=A_BASE+issue_idx; rf_rd_addr_b=B_BASE+issue_idx.
  - A transfer occurs when mul_in_valid and mul_ready are both high; issue_idx then increments.
  - If mul_ready is low, issue_idx holds and the addresses stay stable.
  - A transfer at issue_idx==VLEN-1 moves the state to DRAIN.
- Retire, active in ISSUE and DRAIN, concurrent with issue:
  - On mul_out_valid: rf_we=1 combinationally, rf_wr_addr=C_BASE+retire_idx, rf_wr_data=mul_result.
  - On the same edge, exc_flags[retire_idx] is set to mul_exc and retire_idx increments.
- DRAIN: mul_in_valid=0. When a retire occurs with retire_idx==VLEN-1, move to DONE on that edge.
- DONE: done=1 and held; exc_flags are held. start in DONE restarts exactly as from IDLE (DONE->ISSUE).
- start in ISSUE or DRAIN is ignored.
- mul_out_valid in IDLE or DONE, or a retire with retire_idx > issue_idx: no write; protocol_err is set and sticky until reset.
- Simultaneous issue and retire in one cycle is legal; the two counters are independent.
- The final issue and first retire may coincide; the state is still DRAIN for at least one cycle after the final issue. The exception is a 0-latency multiplier returning the last result on the issue edge, in which case the state goes ISSUE->DONE directly.
- Latency: with mul_ready held high and multiplier latency L, done rises VLEN+L+1 cycles after start is sampled.
- Counters are IDX_W wide; no wrap-around occurs within an operation.

Decomposition:
- Package vfpmul_pkg holds the state enum (IDLE, ISSUE, DRAIN, DONE), the A_BASE/B_BASE/C_BASE defaults, and the exception flag width.
- Single module; no sub-module is warranted. The issue and retire counters are simple enough to inline.

Test Plan:
- Basic run: start with a latency-3 multiplier model, mul_ready=1, A[i]=1.0 (0x3F800000), B[i]=2.0 -> C[64..95]=0x40000000 each, exc_flags=0, done at cycle VLEN+4, busy low once done.
- Backpressure: mul_ready toggles 1/0 every cycle -> 32 issues total, addresses held during stalls, results in order, each C[64+i] correct.
- Exceptions: mul_exc=1 on elements 3 and 31 only -> exc_flags=0x80000008, exc_any=1.
- Abort: assert reset in cycle 10 of ISSUE -> next cycle state IDLE, rf_we=0, exc_flags=0; a subsequent start completes a full 32-element run normally.
- Restart and ignored start: pulse start during DRAIN -> no effect. Then start in DONE -> a second full run with exc_flags cleared on the start edge.
- Protocol error: drive mul_out_valid while in IDLE -> protocol_err=1, no write; it stays high until reset.

Source files
------------

// File: rtl/vfpmul_pkg.sv
// vfpmul_pkg: shared state encoding and address-map defaults for the vector FP multiply sequencer
package vfpmul_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_e;
  localparam int A_BASE_DEF = 0;
  localparam int B_BASE_DEF = 32;
  localparam int C_BASE_DEF = 64;
  localparam int EXC_W      = 32;
endpackage

// File: rtl/vfpmul_sequencer_if.sv
// vfpmul_sequencer_if: register-file and multiplier handshake bundle between sequencer and datapath
interface vfpmul_sequencer_if #(parameter int ADDR_W = 7);
  logic [ADDR_W-1:0] rf_rd_addr_a, rf_rd_addr_b, rf_wr_addr;
  logic [31:0] rf_rd_data_a, rf_rd_data_b, mul_a, mul_b, mul_result, rf_wr_data;
  logic mul_in_valid, mul_ready, mul_out_valid, mul_exc, rf_we;
  modport master (
    output rf_rd_addr_a, rf_rd_addr_b, mul_in_valid, mul_a, mul_b, rf_we, rf_wr_addr, rf_wr_data,
    input  rf_rd_data_a, rf_rd_data_b, mul_ready, mul_out_valid, mul_result, mul_exc
  );
  modport slave (
    input  rf_rd_addr_a, rf_rd_addr_b, mul_in_valid, mul_a, mul_b, rf_we, rf_wr_addr, rf_wr_data,
    output rf_rd_data_a, rf_rd_data_b, mul_ready, mul_out_valid, mul_result, mul_exc
  );
endinterface

// File: rtl/vfpmul_sequencer.sv
// vfpmul_sequencer: issues C[i] = A[i] * B[i] to a pipelined multiplier and retires results in order
module vfpmul_sequencer import vfpmul_pkg::*; #(
  parameter int VLEN   = EXC_W,
  parameter int ADDR_W = 7,
  parameter int A_BASE = A_BASE_DEF,
  parameter int B_BASE = B_BASE_DEF,
  parameter int C_BASE = C_BASE_DEF,
  parameter int IDX_W  = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  vfpmul_sequencer_if.master   m,
  output logic [VLEN-1:0]      exc_flags,
  output logic                 exc_any,
  output logic                 busy,
  output logic                 done,
  output logic                 protocol_err
);
  localparam int EW = $clog2(VLEN);
  state_e state_q, state_d;
  logic [IDX_W-1:0] issue_q, issue_d, retire_q, retire_d;
  logic [VLEN-1:0] exc_q, exc_d;
  logic perr_q, perr_d;
  logic go, xfer, ret, last_iss, last_ret;
  always_comb begin
    busy = state_q == ISSUE || state_q == DRAIN;
    go = start && (state_q == IDLE || state_q == DONE);
    xfer = state_q == ISSUE && m.mul_ready;
    // a result for the element being issued this very cycle is legal (zero-latency multiplier)
    ret = busy && m.mul_out_valid && retire_q <= issue_q;
    last_iss = xfer && issue_q == IDX_W'(VLEN - 1);
    last_ret = ret && retire_q == IDX_W'(VLEN - 1);
    state_d = go ? ISSUE : last_ret ? DONE : last_iss ? DRAIN : state_q;
    issue_d = go ? '0 : issue_q + IDX_W'(xfer);
    retire_d = go ? '0 : retire_q + IDX_W'(ret);
    exc_d = go ? '0 : exc_q;
    if (ret) exc_d[retire_q[EW-1:0]] = m.mul_exc;
    perr_d = perr_q | (m.mul_out_valid && !ret);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      issue_q  <= '0;
      retire_q <= '0;
      exc_q    <= '0;
      perr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      issue_q  <= issue_d;
      retire_q <= retire_d;
      exc_q    <= exc_d;
      perr_q   <= perr_d;
    end
  end
  assign m.mul_in_valid = state_q == ISSUE;
  assign m.rf_rd_addr_a = ADDR_W'(A_BASE + 32'(issue_q));
  assign m.rf_rd_addr_b = ADDR_W'(B_BASE + 32'(issue_q));
  assign m.mul_a = m.rf_rd_data_a;
  assign m.mul_b = m.rf_rd_data_b;
  assign m.rf_we = ret;
  assign m.rf_wr_addr = ADDR_W'(C_BASE + 32'(retire_q));
  assign m.rf_wr_data = m.mul_result;
  assign done = state_q == DONE;
  assign exc_flags = exc_q;
  assign exc_any = |exc_q;
  assign protocol_err = perr_q;
endmodule

// File: tb/tb_vfpmul_sequencer.sv
// tb_vfpmul_sequencer: random-stimulus bench with a register-file/multiplier model and an in-order write scoreboard
module tb_vfpmul_sequencer;
  localparam int VLEN = 32;
  logic clk = 0, reset = 1, start = 0;
  logic [VLEN-1:0] exc_flags;
  logic exc_any, busy, done, protocol_err;
  int nvec = 0, nerr = 0;
  int lat = 3, mode = 0;
  logic [31:0] exc_pat = '0;
  logic [31:0] opa [VLEN];
  logic [31:0] opb [VLEN];
  logic ready_q = 1, inj_ov = 0;
  logic pv [4];
  logic [31:0] pr [4];
  logic pe [4];
  vfpmul_sequencer_if #(.ADDR_W(7)) bus ();
  vfpmul_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .m(bus),
    .exc_flags(exc_flags), .exc_any(exc_any), .busy(busy), .done(done), .protocol_err(protocol_err)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic [47:0] m;
    logic [7:0] e;
    m = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    e = a[30:23] + b[30:23] - 8'd127;
    return m[47] ? {a[31] ^ b[31], e + 8'd1, m[46:24]} : {a[31] ^ b[31], e, m[45:23]};
  endfunction
  always_comb begin
    bus.rf_rd_data_a = opa[bus.rf_rd_addr_a[4:0]];
    bus.rf_rd_data_b = opb[bus.rf_rd_addr_b[4:0]];
    bus.mul_ready = ready_q;
    bus.mul_out_valid = (lat == 0 ? (bus.mul_in_valid && bus.mul_ready) : pv[lat-1]) | inj_ov;
    bus.mul_result = lat == 0 ? fmul(bus.mul_a, bus.mul_b) : pr[lat == 0 ? 0 : lat-1];
    bus.mul_exc = lat == 0 ? exc_pat[bus.rf_rd_addr_a[4:0]] : pe[lat == 0 ? 0 : lat-1];
  end
  always @(posedge clk) begin
    ready_q <= mode == 0 ? 1'b1 : mode == 1 ? ~ready_q : 1'($urandom_range(0, 1));
    if (reset) begin
      for (int k = 0; k < 4; k++) pv[k] <= 1'b0;
    end else begin
      pv[0] <= bus.mul_in_valid && bus.mul_ready;
      pr[0] <= fmul(bus.mul_a, bus.mul_b);
      pe[0] <= exc_pat[bus.rf_rd_addr_a[4:0]];
      for (int k = 1; k < 4; k++) begin
        pv[k] <= pv[k-1];
        pr[k] <= pr[k-1];
        pe[k] <= pe[k-1];
      end
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic load(input bit rnd);
    for (int i = 0; i < VLEN; i++) begin
      opa[i] = rnd ? $urandom : 32'h3F800000;
      opb[i] = rnd ? $urandom : 32'h40000000;
    end
  endtask
  task automatic run(input int l, input int md, input logic [31:0] ep, input bit rnd, input bit poke);
    logic [31:0] expd [VLEN];
    int iss = 0, wr = 0, n = 0;
    bit stall = 0, poked = 0;
    logic [6:0] ha = '0, hb = '0;
    lat = l;
    mode = md;
    exc_pat = ep;
    load(rnd);
    for (int i = 0; i < VLEN; i++) expd[i] = fmul(opa[i], opb[i]);
    start = 1;
    tick();
    start = 0;
    n = 1;
    chk("busy_on_start", 64'(busy), 1);
    chk("exc_clr_on_start", 64'(exc_flags), 0);
    while (!done && n < 3000) begin
      if (bus.mul_in_valid && stall) begin
        chk("hold_addr_a", 64'(bus.rf_rd_addr_a), 64'(ha));
        chk("hold_addr_b", 64'(bus.rf_rd_addr_b), 64'(hb));
      end
      if (bus.mul_in_valid && bus.mul_ready && iss < VLEN) begin
        chk("rd_addr_a", 64'(bus.rf_rd_addr_a), 64'(iss));
        chk("rd_addr_b", 64'(bus.rf_rd_addr_b), 64'(32 + iss));
        chk("mul_a", 64'(bus.mul_a), 64'(opa[iss]));
        chk("mul_b", 64'(bus.mul_b), 64'(opb[iss]));
        iss++;
      end
      stall = bus.mul_in_valid && !bus.mul_ready;
      ha = bus.rf_rd_addr_a;
      hb = bus.rf_rd_addr_b;
      if (bus.rf_we) begin
        chk("wr_addr", 64'(bus.rf_wr_addr), 64'(64 + wr));
        chk("wr_data", 64'(bus.rf_wr_data), wr < VLEN ? 64'(expd[wr]) : 64'hDEAD);
        wr++;
      end
      if (poke && !poked && busy && !bus.mul_in_valid) begin
        start = 1;
        poked = 1;
      end
      tick();
      start = 0;
      n++;
    end
    chk("done_reached", 64'(done), 1);
    if (md == 0) chk("done_latency", 64'(n), 64'(VLEN + l + 1));
    if (poke) chk("drain_poked", 64'(poked), 1);
    chk("issue_count", 64'(iss), VLEN);
    chk("write_count", 64'(wr), VLEN);
    chk("exc_flags", 64'(exc_flags), 64'(ep));
    chk("exc_any", 64'(exc_any), 64'(|ep));
    chk("busy_off", 64'(busy), 0);
    chk("no_perr", 64'(protocol_err), 0);
    tick();
    chk("done_held", 64'(done), 1);
    chk("flags_held", 64'(exc_flags), 64'(ep));
    chk("no_write_in_done", 64'(bus.rf_we), 0);
  endtask
  initial begin
    load(0);
    reset = 1;
    tick();
    chk("rst_busy", 64'(busy), 0);
    chk("rst_done", 64'(done), 0);
    chk("rst_in_valid", 64'(bus.mul_in_valid), 0);
    chk("rst_we", 64'(bus.rf_we), 0);
    chk("rst_flags", 64'(exc_flags), 0);
    chk("rst_perr", 64'(protocol_err), 0);
    reset = 0;
    tick();
    run(3, 0, 32'h0, 0, 0);
    run(2, 1, 32'h0, 1, 0);
    run(3, 2, 32'h80000008, 1, 0);
    lat = 3;
    mode = 0;
    exc_pat = '1;
    load(1);
    start = 1;
    tick();
    start = 0;
    repeat (10) tick();
    chk("pre_abort_busy", 64'(busy), 1);
    chk("pre_abort_flags", 64'(exc_flags != 0), 1);
    reset = 1;
    tick();
    reset = 0;
    chk("abort_busy", 64'(busy), 0);
    chk("abort_done", 64'(done), 0);
    chk("abort_we", 64'(bus.rf_we), 0);
    chk("abort_in_valid", 64'(bus.mul_in_valid), 0);
    chk("abort_flags", 64'(exc_flags), 0);
    repeat (4) begin
      tick();
      chk("abort_no_write", 64'(bus.rf_we), 0);
    end
    run(3, 0, 32'h0, 1, 0);
    run(3, 0, 32'h000000F0, 1, 1);
    run(1, 0, 32'h0, 1, 0);
    run(0, 0, 32'h00000001, 1, 0);
    reset = 1;
    tick();
    reset = 0;
    inj_ov = 1;
    #1;
    chk("perr_no_write", 64'(bus.rf_we), 0);
    tick();
    inj_ov = 0;
    chk("perr_set", 64'(protocol_err), 1);
    repeat (5) tick();
    chk("perr_sticky", 64'(protocol_err), 1);
    reset = 1;
    tick();
    reset = 0;
    chk("perr_cleared", 64'(protocol_err), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
